// File: rtl/dds_param_ctrl_pkg.sv
// Shared encodings for the DDS button-driven configuration controller.
package dds_param_ctrl_pkg;

    localparam logic EDIT_FREQ = 1'b0;
    localparam logic EDIT_WAVE = 1'b1;

    localparam logic [1:0] WAVE_SINE = 2'd0;
    localparam logic [1:0] WAVE_SQR  = 2'd1;
    localparam logic [1:0] WAVE_TRI  = 2'd2;
    localparam logic [1:0] WAVE_SAW  = 2'd3;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;
    localparam logic [1:0] ST_LOCK   = 2'd3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dds_rpt_timer.sv
// Loadable countdown that parks at zero; zero flag drives hold/repeat timing.
module dds_rpt_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/dds_param_ctrl.sv
// Button FSM editing DDS waveform select and tuning word, with auto-repeat,
// acceleration and saturating arithmetic; strobes oUpdate on real changes.
module dds_param_ctrl
    import dds_param_ctrl_pkg::*;
#(
    parameter int                  TW_WIDTH    = 32,
    parameter logic [TW_WIDTH-1:0] TW_DEFAULT  = 32'd1000,
    parameter logic [TW_WIDTH-1:0] TW_MIN      = 32'd100,
    parameter logic [TW_WIDTH-1:0] TW_MAX      = 32'd10000,
    parameter logic [TW_WIDTH-1:0] TW_STEP     = 32'd100,
    parameter int                  HOLD_CYC    = 25_000_000,
    parameter int                  REP_CYC     = 5_000_000,
    parameter int                  ACCEL_CNT   = 8,
    parameter int                  ACCEL_SHIFT = 4
) (
    input  logic                Fg_CLK,
    input  logic                RESETn,
    input  logic                iBtnMode,
    input  logic                iBtnUp,
    input  logic                iBtnDn,
    output logic                oEditSel,
    output logic [1:0]          oWaveSel,
    output logic [TW_WIDTH-1:0] oTuneWord,
    output logic                oUpdate
);

    localparam int TMR_W = $clog2(max_int(HOLD_CYC, REP_CYC) + 1);
    localparam int RPT_W = $clog2(ACCEL_CNT + 2);
    localparam logic [RPT_W-1:0] RPT_MAX = RPT_W'(ACCEL_CNT);

    logic [1:0]          state, state_n;
    logic                prev_mode, prev_up, prev_dn;
    logic                dir, dir_n;
    logic [RPT_W-1:0]    rpt, rpt_n;
    logic                edit_n;
    logic [1:0]          wave_n;
    logic [TW_WIDTH-1:0] tw_n;
    logic                act, act_up, coarse;
    logic                tmr_load, tmr_dec, tmr_zero;
    logic [TMR_W-1:0]    tmr_val;
    logic [TW_WIDTH-1:0] step, tw_inc, tw_dec;
    logic [TW_WIDTH:0]   sum, diff;
    logic                mode_rise, up_rise, dn_rise, held, other;

    assign mode_rise = iBtnMode & ~prev_mode;
    assign up_rise   = iBtnUp & ~prev_up;
    assign dn_rise   = iBtnDn & ~prev_dn;
    assign held      = dir ? iBtnUp : iBtnDn;
    assign other     = dir ? iBtnDn : iBtnUp;

    // Every auto-repeat (including the first one out of HOLD) bumps the count;
    // the step uses the count before that bump, so a fresh press is always fine.
    assign coarse = (state != ST_IDLE) && (rpt == RPT_MAX);
    assign step   = coarse ? (TW_STEP << ACCEL_SHIFT) : TW_STEP;
    assign sum    = {1'b0, oTuneWord} + {1'b0, step};
    assign diff   = {1'b0, oTuneWord} - {1'b0, step};
    assign tw_inc = (sum > {1'b0, TW_MAX}) ? TW_MAX : sum[TW_WIDTH-1:0];
    assign tw_dec = (diff[TW_WIDTH] || diff < {1'b0, TW_MIN}) ? TW_MIN : diff[TW_WIDTH-1:0];

    always_comb begin
        state_n  = state;
        edit_n   = oEditSel;
        dir_n    = dir;
        rpt_n    = rpt;
        act      = 1'b0;
        act_up   = dir;
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_dec  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (iBtnUp && iBtnDn) begin
                    state_n = ST_LOCK;
                end else if (up_rise || dn_rise) begin
                    act      = 1'b1;
                    act_up   = up_rise;
                    dir_n    = up_rise;
                    rpt_n    = '0;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(HOLD_CYC - 1);
                    state_n  = ST_HOLD;
                end else if (mode_rise && !iBtnUp && !iBtnDn) begin
                    edit_n = ~oEditSel;
                end
            end
            ST_HOLD, ST_REPEAT: begin
                if (!held) begin
                    state_n = ST_IDLE;
                end else if (other) begin
                    state_n = ST_LOCK;
                end else if (tmr_zero) begin
                    act      = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(REP_CYC - 1);
                    state_n  = ST_REPEAT;
                    if (rpt != RPT_MAX)
                        rpt_n = rpt + 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: begin
                if (!iBtnUp && !iBtnDn)
                    state_n = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        tw_n   = oTuneWord;
        wave_n = oWaveSel;
        if (act) begin
            if (oEditSel == EDIT_FREQ)
                tw_n = act_up ? tw_inc : tw_dec;
            else
                wave_n = act_up ? oWaveSel + 2'd1 : oWaveSel - 2'd1;
        end
    end

    dds_rpt_timer #(.W(TMR_W)) u_timer (
        .clk      (Fg_CLK),
        .rst_n    (RESETn),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) begin
            state     <= ST_IDLE;
            prev_mode <= 1'b0;
            prev_up   <= 1'b0;
            prev_dn   <= 1'b0;
            dir       <= 1'b0;
            rpt       <= '0;
            oEditSel  <= EDIT_FREQ;
            oWaveSel  <= WAVE_SINE;
            oTuneWord <= TW_DEFAULT;
            oUpdate   <= 1'b0;
        end else begin
            state     <= state_n;
            prev_mode <= iBtnMode;
            prev_up   <= iBtnUp;
            prev_dn   <= iBtnDn;
            dir       <= dir_n;
            rpt       <= rpt_n;
            oEditSel  <= edit_n;
            oWaveSel  <= wave_n;
            oTuneWord <= tw_n;
            oUpdate   <= (tw_n != oTuneWord) || (wave_n != oWaveSel);
        end
    end

endmodule
